nios_mult_unit: RTL and testbench
=================================

# nios_mult_unit

Parametrised, pipelined integer multiplier for the Nios II execute/memory path. It supersedes the fixed 32-bit three-partial-product cell. It computes the full 2·DATA_W-bit product from four half-width partial products and supports signed, unsigned and mixed-sign operation. It returns either the low word (MUL) or the high word (MULXUU/MULXSS/MULXSU), and carries a tag, a valid bit, stall and flush through a fixed 3-stage pipeline.

## Interface
- DATA_W, 32: operand/result width; even, 16..64; H = DATA_W/2
- TAG_W, 5: width of sideband tag (destination register index)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  pipeline advance; 0 freezes every stage (stall)
- flush  in  1  synchronous kill of all in-flight operations
- in_valid  in  1  operation presented this cycle
- in_op  in  2  operation code (MUL, MULXUU, MULXSS, MULXSU)
- in_a  in  DATA_W  multiplicand
- in_b  in  DATA_W  multiplier
- in_tag  in  TAG_W  sideband, returned unchanged with result
- out_valid  out  1  out_result/out_tag valid
- out_result  out  DATA_W  selected product word
- out_tag  out  TAG_W  tag of the completing operation
- busy  out  1  OR of valid bits in stages 1–3

## Operation
- Op encodings: MUL=0 → low DATA_W bits, signedness irrelevant. MULXUU=1 → high word, a and b unsigned. MULXSS=2 → high word, a and b signed. MULXSU=3 → high word, a signed, b unsigned.
- Operand halves: a_lo/b_lo are zero-extended to H+1 bits. a_hi is sign-extended if a is signed, else zero-extended. Same rule for b_hi.
- Partial products, each signed (2H+2) bits: pp_ll=a_lo·b_lo, pp_lh=a_lo·b_hi, pp_hl=a_hi·b_lo, pp_hh=a_hi·b_hi.
- Sum: P = pp_ll + ((pp_lh+pp_hl) << H) + (pp_hh << 2H). Each term is sign-extended to 2·DATA_W bits and the sum is taken modulo 2^(2·DATA_W). P equals the exact product of the operands under the selected signedness.
- Stage 1 (S1): register in_a, in_b, in_op, in_tag and the valid bit (v1 ← in_valid).
- Stage 2 (S2): register the four partial products, op, tag and v2.
- Stage 3 (S3): register the sum, then the word select, into out_result. Also register out_tag and out_valid.
- Stall: when en=0, all data and valid registers hold. out_valid stays asserted if it was set. The consumer may sample the result repeatedly.
- Flush: v1, v2 and out_valid clear on the next edge, regardless of en. An in_valid presented in the same cycle is discarded. Data registers are don't-care.
- Flush while en=0: valids still clear. flush has priority over en.
- Reset: v1, v2, out_valid, out_result, out_tag all become 0. busy becomes 0. Reset has priority over flush and en.
- Back-to-back issue: one operation per cycle with en=1. No bubbles and no internal hazards.

## Timing
- Latency: an operation accepted at edge k (in_valid=1, en=1, no flush) produces out_valid=1 after edge k+3, counting only edges with en=1.
- Throughput: 1 op per enabled cycle.
- Outputs are registered. There is no combinational path from any input to any output.
- en low on N cycles delays completion by exactly N cycles.
- Reset asserted mid-operation: everything in flight is lost. The first operation after reset deassertion completes 3 enabled edges after acceptance.

## Structure
- Package nios_mult_pkg:
  - op enum: MUL, MULXUU, MULXSS, MULXSU (2 bits)
  - helper functions `op_a_signed(op)` and `op_b_signed(op)`
  - localparam for pipeline depth = 3
- Sub-module nios_mult_pp: one registered (H+1)×(H+1) signed multiplier with en. It is instantiated four times in S2 and maps to one DSP block each.
- Top nios_mult_unit contains the operand extension, the S1/S3 registers, the adder tree, the word select and the valid/flush/stall control.

## Test plan
- DATA_W=32, MUL 0x0000FFFF×0x0000FFFF, en=1 → out_result=0xFFFE0001 three cycles later, out_tag echoed.
- MULXUU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULXSS on the same operands → 0x00000000. MUL on the same operands → 0x00000001.
- MULXSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF (P=0xFFFFFFFF00000001). MULXSS 0x80000000×0x80000000 → 0x40000000.
- Back-to-back stream of 4 ops with distinct tags, then en=0 for 2 cycles mid-stream. Required: results arrive in order, each delayed exactly 2 cycles, and out_valid holds during the stall.
- Two ops in flight, then flush=1 with en=0 and a new in_valid in the same cycle. Required: no out_valid ever fires for any of the three, and busy=0 on the next cycle.
- reset pulsed with 3 ops in flight. Required: out_valid=0, out_result=0, busy=0 the next cycle. Then a MUL 3×5 completes with 0x0000000F after 3 cycles; repeat at DATA_W=16 with 0xFFFF×0xFFFF MULXUU → 0xFFFE.

Source files
------------

// File: rtl/nios_mult_pkg.sv
// Shared definitions for the Nios II pipelined multiplier: opcodes, pipeline
// depth and the per-operand signedness decode.
package nios_mult_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'd0,
    OP_MULXUU = 2'd1,
    OP_MULXSS = 2'd2,
    OP_MULXSU = 2'd3
  } mult_op_e;

  localparam int unsigned PIPE_DEPTH = 3;

  function automatic logic op_a_signed(mult_op_e op);
    return (op == OP_MULXSS) || (op == OP_MULXSU);
  endfunction

  function automatic logic op_b_signed(mult_op_e op);
    return (op == OP_MULXSS);
  endfunction

endpackage

// File: rtl/nios_mult_if.sv
// Issue/complete bundle of the multiplier; master drives operations and
// pipeline control, slave (the multiplier) returns results and busy.
interface nios_mult_if
  import nios_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) ();

  logic              en;
  logic              flush;
  logic              in_valid;
  mult_op_e          in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic [DATA_W-1:0] out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport master (
    output en, flush, in_valid, in_op, in_a, in_b, in_tag,
    input  out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  en, flush, in_valid, in_op, in_a, in_b, in_tag,
    output out_valid, out_result, out_tag, busy
  );

endinterface

// File: rtl/nios_mult_pp.sv
// One registered signed W x W partial-product multiplier with clock enable;
// sized so each instance fits a single DSP block.
module nios_mult_pp #(
  parameter int W = 17
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic signed [W-1:0]  a_i,
  input  logic signed [W-1:0]  b_i,
  output logic signed [2*W-1:0] p_o
);

  logic signed [2*W-1:0] p_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      p_q <= a_i * b_i;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/nios_mult_unit.sv
// Three-stage pipelined DATA_W x DATA_W multiplier returning the low or high
// product word with tag, valid, stall (en) and flush handling.
module nios_mult_unit
  import nios_mult_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic       clk,
  input  logic       reset,
  nios_mult_if.slave bus
);

  localparam int H    = DATA_W / 2;
  localparam int PP_W = 2 * H + 2;
  localparam int P_W  = 2 * DATA_W;

  // Stage 1: operand capture
  logic [DATA_W-1:0] a1_q, b1_q;
  mult_op_e          op1_q;
  logic [TAG_W-1:0]  tag1_q;

  // Stage 2: partial products plus sideband
  mult_op_e          op2_q;
  logic [TAG_W-1:0]  tag2_q;
  logic signed [PP_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  // Stage 3: selected word
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q;

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (bus.flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else if (bus.en) begin
      v1_d = bus.in_valid;
      v2_d = v1_q;
      v3_d = v2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en) begin
      a1_q   <= bus.in_a;
      b1_q   <= bus.in_b;
      op1_q  <= bus.in_op;
      tag1_q <= bus.in_tag;
      op2_q  <= op1_q;
      tag2_q <= tag1_q;
    end
  end

  // Low halves are always unsigned; only the high halves carry operand sign.
  logic a_sgn, b_sgn;
  logic signed [H:0] a_lo_x, a_hi_x, b_lo_x, b_hi_x;

  assign a_sgn  = op_a_signed(op1_q);
  assign b_sgn  = op_b_signed(op1_q);
  assign a_lo_x = {1'b0, a1_q[H-1:0]};
  assign b_lo_x = {1'b0, b1_q[H-1:0]};
  assign a_hi_x = {a_sgn & a1_q[DATA_W-1], a1_q[DATA_W-1:H]};
  assign b_hi_x = {b_sgn & b1_q[DATA_W-1], b1_q[DATA_W-1:H]};

  nios_mult_pp #(.W(H + 1)) u_pp_ll (
    .clk(clk), .en_i(bus.en), .a_i(a_lo_x), .b_i(b_lo_x), .p_o(pp_ll)
  );
  nios_mult_pp #(.W(H + 1)) u_pp_lh (
    .clk(clk), .en_i(bus.en), .a_i(a_lo_x), .b_i(b_hi_x), .p_o(pp_lh)
  );
  nios_mult_pp #(.W(H + 1)) u_pp_hl (
    .clk(clk), .en_i(bus.en), .a_i(a_hi_x), .b_i(b_lo_x), .p_o(pp_hl)
  );
  nios_mult_pp #(.W(H + 1)) u_pp_hh (
    .clk(clk), .en_i(bus.en), .a_i(a_hi_x), .b_i(b_hi_x), .p_o(pp_hh)
  );

  function automatic logic [P_W-1:0] sx(input logic [PP_W-1:0] pp);
    return {{(P_W - PP_W){pp[PP_W-1]}}, pp};
  endfunction

  logic [P_W-1:0] prod;

  assign prod = sx(pp_ll)
              + ((sx(pp_lh) + sx(pp_hl)) << H)
              + (sx(pp_hh) << (2 * H));

  assign out_result_d = (op2_q == OP_MUL) ? prod[DATA_W-1:0] : prod[P_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (bus.en) begin
      out_result_q <= out_result_d;
      out_tag_q    <= tag2_q;
    end
  end

  assign bus.out_valid  = v3_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.busy       = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_nios_mult_unit.sv
// Scoreboard bench for nios_mult_unit at DATA_W=32 and DATA_W=16 with
// directed vectors, stall, flush and reset scenarios.
module tb_nios_mult_unit;
  import nios_mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, rst16;

  nios_mult_if #(.DATA_W(32), .TAG_W(5)) if32 ();
  nios_mult_if #(.DATA_W(16), .TAG_W(5)) if16 ();

  nios_mult_unit #(.DATA_W(32), .TAG_W(5)) dut32 (.clk(clk), .reset(rst32), .bus(if32));
  nios_mult_unit #(.DATA_W(16), .TAG_W(5)) dut16 (.clk(clk), .reset(rst16), .bus(if16));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          due;
  } exp_t;

  typedef struct {
    mult_op_e    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;

  int          en_cnt[2]   = '{0, 0};
  bit          edge_en[2]  = '{0, 0};
  bit          stall_e[2]  = '{0, 0};
  bit          kill_e[2]   = '{0, 0};
  bit          prev_ov[2]  = '{0, 0};
  logic [31:0] prev_res[2];
  logic [4:0]  prev_tag[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Classify each edge per DUT so the monitor knows what to expect after it.
  always @(posedge clk) begin
    kill_e[0]  = rst32 || if32.flush;
    stall_e[0] = !kill_e[0] && !if32.en;
    edge_en[0] = !kill_e[0] && if32.en;
    if (if32.en) en_cnt[0]++;
    kill_e[1]  = rst16 || if16.flush;
    stall_e[1] = !kill_e[1] && !if16.en;
    edge_en[1] = !kill_e[1] && if16.en;
    if (if16.en) en_cnt[1]++;
  end

  task automatic mon_step(input int d, input logic ov, input logic [31:0] res, input logic [4:0] tag);
    exp_t e;
    int   qs;
    qs = (d == 0) ? q0.size() : q1.size();
    if (kill_e[d]) begin
      chk($sformatf("dut%0d killed_valid", d), {31'd0, ov}, 32'd0);
    end else if (stall_e[d]) begin
      if (prev_ov[d]) begin
        chk($sformatf("dut%0d hold_valid", d), {31'd0, ov}, 32'd1);
        chk($sformatf("dut%0d hold_result", d), res, prev_res[d]);
        chk($sformatf("dut%0d hold_tag", d), 32'(tag), 32'(prev_tag[d]));
      end
    end else if (edge_en[d] && ov) begin
      if (qs == 0) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected_valid: got result 0x%08h tag %0d, expected no output", d, res, tag);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("dut%0d result tag%0d", d, e.tag), res, e.res);
        chk($sformatf("dut%0d tag", d), 32'(tag), 32'(e.tag));
        chk($sformatf("dut%0d latency tag%0d", d, e.tag), 32'(en_cnt[d]), 32'(e.due));
      end
    end
    prev_ov[d]  = ov;
    prev_res[d] = res;
    prev_tag[d] = tag;
  endtask

  always @(negedge clk) begin
    mon_step(0, if32.out_valid, if32.out_result, if32.out_tag);
    mon_step(1, if16.out_valid, {16'd0, if16.out_result}, if16.out_tag);
  end

  task automatic issue(input int d, input mult_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp);
    exp_t e;
    @(negedge clk);
    e.res = exp;
    e.tag = tag;
    e.due = en_cnt[d] + 3;
    if (d == 0) begin
      if32.en = 1'b1; if32.flush = 1'b0; if32.in_valid = 1'b1;
      if32.in_op = op; if32.in_a = a; if32.in_b = b; if32.in_tag = tag;
      q0.push_back(e);
    end else begin
      if16.en = 1'b1; if16.flush = 1'b0; if16.in_valid = 1'b1;
      if16.in_op = op; if16.in_a = a[15:0]; if16.in_b = b[15:0]; if16.in_tag = tag;
      q1.push_back(e);
    end
  endtask

  task automatic idle(input int d, input int n, input logic en_v);
    repeat (n) begin
      @(negedge clk);
      if (d == 0) begin if32.in_valid = 1'b0; if32.en = en_v; if32.flush = 1'b0; end
      else        begin if16.in_valid = 1'b0; if16.en = en_v; if16.flush = 1'b0; end
    end
  endtask

  task automatic drain(input int d);
    int t = 0;
    idle(d, 1, 1'b1);
    while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (((d == 0) ? q0.size() : q1.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d drain_timeout: %0d results outstanding, expected 0", d,
               (d == 0) ? q0.size() : q1.size());
      if (d == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic check_cleared(input int d, input string what);
    if (d == 0) begin
      chk({what, " dut0 out_valid"}, {31'd0, if32.out_valid}, 32'd0);
      chk({what, " dut0 out_result"}, if32.out_result, 32'd0);
      chk({what, " dut0 out_tag"}, 32'(if32.out_tag), 32'd0);
      chk({what, " dut0 busy"}, {31'd0, if32.busy}, 32'd0);
    end else begin
      chk({what, " dut1 out_valid"}, {31'd0, if16.out_valid}, 32'd0);
      chk({what, " dut1 out_result"}, {16'd0, if16.out_result}, 32'd0);
      chk({what, " dut1 out_tag"}, 32'(if16.out_tag), 32'd0);
      chk({what, " dut1 busy"}, {31'd0, if16.busy}, 32'd0);
    end
  endtask

  // Reset with ops in flight; everything queued is lost.
  task automatic reset_pulse(input int d);
    @(negedge clk);
    if (d == 0) begin rst32 = 1'b1; if32.in_valid = 1'b0; end
    else        begin rst16 = 1'b1; if16.in_valid = 1'b0; end
    @(posedge clk);
    #1;
    if (d == 0) q0.delete(); else q1.delete();
    @(negedge clk);
    check_cleared(d, "reset_pulse");
    if (d == 0) rst32 = 1'b0; else rst16 = 1'b0;
  endtask

  vec_t v32[10] = '{
    '{OP_MUL,    32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001},
    '{OP_MULXUU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{OP_MULXSS, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
    '{OP_MULXSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{OP_MULXSS, 32'h80000000, 32'h80000000, 32'h40000000},
    '{OP_MULXSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780},
    '{OP_MULXUU, 32'h12345678, 32'h00000010, 32'h00000001},
    '{OP_MULXSS, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF}
  };

  vec_t v16[5] = '{
    '{OP_MULXUU, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFE},
    '{OP_MULXSS, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000},
    '{OP_MUL,    32'h0000FFFF, 32'h0000FFFF, 32'h00000001},
    '{OP_MULXSU, 32'h00008000, 32'h0000FFFF, 32'h00008000},
    '{OP_MUL,    32'h00000003, 32'h00000005, 32'h0000000F}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst32 = 1'b1; rst16 = 1'b1;
    if32.en = 1'b0; if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_op = OP_MUL;
    if32.in_a = '0; if32.in_b = '0; if32.in_tag = '0;
    if16.en = 1'b0; if16.flush = 1'b0; if16.in_valid = 1'b0; if16.in_op = OP_MUL;
    if16.in_a = '0; if16.in_b = '0; if16.in_tag = '0;
    repeat (3) @(negedge clk);
    check_cleared(0, "reset");
    check_cleared(1, "reset");
    rst32 = 1'b0;

    foreach (v32[i]) issue(0, v32[i].op, v32[i].a, v32[i].b, 5'(i + 1), v32[i].exp);
    drain(0);

    // Stall two cycles while the first result is on the output.
    issue(0, OP_MUL,    32'h00000007, 32'h00000009, 5'd11, 32'h0000003F);
    issue(0, OP_MUL,    32'h00000100, 32'h00000100, 5'd12, 32'h00010000);
    issue(0, OP_MULXUU, 32'h80000000, 32'h00000004, 5'd13, 32'h00000002);
    idle(0, 2, 1'b0);
    issue(0, OP_MUL,    32'hFFFFFFFF, 32'h00000002, 5'd14, 32'hFFFFFFFE);
    drain(0);

    // Flush with en=0 and a colliding new op: none of the three may complete.
    issue(0, OP_MUL, 32'h00000002, 32'h00000003, 5'd15, 32'h00000006);
    issue(0, OP_MUL, 32'h00000004, 32'h00000005, 5'd16, 32'h00000014);
    @(negedge clk);
    if32.en = 1'b0; if32.flush = 1'b1; if32.in_valid = 1'b1;
    if32.in_a = 32'd3; if32.in_b = 32'd5; if32.in_tag = 5'd17;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    chk("flush busy", {31'd0, if32.busy}, 32'd0);
    chk("flush out_valid", {31'd0, if32.out_valid}, 32'd0);
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.en = 1'b1;
    idle(0, 5, 1'b1);

    issue(0, OP_MUL, 32'h00000002, 32'h00000002, 5'd18, 32'h00000004);
    issue(0, OP_MUL, 32'h00000006, 32'h00000006, 5'd19, 32'h00000024);
    issue(0, OP_MUL, 32'h00000008, 32'h00000008, 5'd20, 32'h00000040);
    reset_pulse(0);
    idle(0, 3, 1'b1);
    issue(0, OP_MUL, 32'h00000003, 32'h00000005, 5'd21, 32'h0000000F);
    drain(0);

    rst16 = 1'b0;
    foreach (v16[i]) issue(1, v16[i].op, v16[i].a, v16[i].b, 5'(i + 1), v16[i].exp);
    drain(1);
    issue(1, OP_MUL, 32'h00000002, 32'h00000007, 5'd6, 32'h0000000E);
    issue(1, OP_MUL, 32'h00000003, 32'h00000007, 5'd7, 32'h00000015);
    issue(1, OP_MUL, 32'h00000004, 32'h00000007, 5'd8, 32'h0000001C);
    reset_pulse(1);
    idle(1, 2, 1'b1);
    issue(1, OP_MULXUU, 32'h0000FFFF, 32'h0000FFFF, 5'd9, 32'h0000FFFE);
    drain(1);
    idle(1, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
